// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read RAM between two requesters.
// Port 0 is the CPU controller (fetch, LDR/STR); port 1 is the loader/debug port.
// Commands are one-hot (001 NONE, 010 READ, 100 WRITE); everything else is illegal
// and sets the sticky err flag when seen in IDLE.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   cmd0/addr0/wdata0        port 0 request (held until ack0)
//   ack0, rdata0             port 0 one-cycle completion pulse, read data
//   cmd1/addr1/wdata1        port 1 request (held until ack1)
//   ack1, rdata1             port 1 one-cycle completion pulse, read data
//   ram_addr/ram_din/ram_write  registered RAM command
//   ram_dout                 RAM read data, valid one cycle after ram_addr
//   busy, owner, err         status: not idle, last granted port, sticky illegal cmd
//
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise
// port 0 has fixed priority.
module mem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    cmd0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic [2:0]    cmd1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_write,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          owner,
  output logic          err
);

  localparam logic [2:0] CMD_NONE  = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RCAP = 3'd2,
    S_WR   = 3'd3,
    S_ACK  = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] din_d;
  logic          write_d;
  logic          owner_d;
  logic          err_d;
  logic [DW-1:0] rdata0_d, rdata1_d;
  logic          ack0_d, ack1_d, busy_d;
  logic          req0, req1, ill0, ill1;
  logic          grant;
  logic [2:0]    gcmd;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gwdata;
`ifdef MEM_ARB_RR_EN
  logic          prio, prio_d;  // port favoured on the next tie
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_write <= 1'b0;
      owner     <= 1'b0;
      err       <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      prio      <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      ram_addr  <= addr_d;
      ram_din   <= din_d;
      ram_write <= write_d;
      owner     <= owner_d;
      err       <= err_d;
      rdata0    <= rdata0_d;
      rdata1    <= rdata1_d;
      ack0      <= ack0_d;
      ack1      <= ack1_d;
      busy      <= busy_d;
`ifdef MEM_ARB_RR_EN
      prio      <= prio_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    addr_d   = ram_addr;
    din_d    = ram_din;
    write_d  = 1'b0;
    owner_d  = owner;
    err_d    = err;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
    grant    = 1'b0;
    gcmd     = CMD_NONE;
    gaddr    = addr0;
    gwdata   = wdata0;
`ifdef MEM_ARB_RR_EN
    prio_d   = prio;
`endif

    req0 = (cmd0 == CMD_READ) || (cmd0 == CMD_WRITE);
    req1 = (cmd1 == CMD_READ) || (cmd1 == CMD_WRITE);
    ill0 = !req0 && (cmd0 != CMD_NONE);
    ill1 = !req1 && (cmd1 != CMD_NONE);

    case (state)
      S_IDLE: begin
        err_d = err | ill0 | ill1;
        if (req0 || req1) begin
`ifdef MEM_ARB_RR_EN
          grant  = (req0 && req1) ? prio : req1;
          prio_d = ~grant;
`else
          grant  = !req0;
`endif
          gcmd    = grant ? cmd1 : cmd0;
          gaddr   = grant ? addr1 : addr0;
          gwdata  = grant ? wdata1 : wdata0;
          owner_d = grant;
          addr_d  = gaddr;
          din_d   = gwdata;
          if (gcmd == CMD_READ) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
            write_d = 1'b1;
          end
        end
      end
      S_RD:   state_d = S_RCAP;
      S_RCAP: begin
        // RAM output is valid now; only the owner's rdata moves
        if (owner) rdata1_d = ram_dout;
        else       rdata0_d = ram_dout;
        state_d = S_ACK;
      end
      S_WR:   state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ack0_d = (state_d == S_ACK) && !owner_d;
    ack1_d = (state_d == S_ACK) && owner_d;
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural sync-read RAM.
module tb_mem_arbiter;

  localparam logic [2:0] NONE = 3'b001;
  localparam logic [2:0] RD   = 3'b010;
  localparam logic [2:0] WR   = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cmd0, cmd1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_write;
  logic [15:0] ram_dout;
  logic        busy, owner, err;

  logic [15:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Synchronous-read RAM with a bench-side preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write), .ram_dout(ram_dout),
    .busy(busy), .owner(owner), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd0 = NONE; cmd1 = NONE;
    step();
    step();
  endtask

  task automatic test_reset();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    do_reset();
    total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL reset_ram_write got=%b exp=0", ram_write); end
    total++; if (ram_addr !== 8'h00) begin bad++; $display("FAIL reset_ram_addr got=%h exp=00", ram_addr); end
    total++; if (ram_din !== 16'h0000) begin bad++; $display("FAIL reset_ram_din got=%h exp=0000", ram_din); end
    total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b exp=00", {ack0, ack1}); end
    total++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rdata0, rdata1); end
    total++; if ({owner, err, busy} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b exp=000", {owner, err, busy}); end
    reset = 1'b0;
  endtask

  task automatic test_read();
    preload(8'h05, 16'hBEEF);
    cmd0 = RD; addr0 = 8'h05;
    step();
    total++; if (busy !== 1'b1 || ram_addr !== 8'h05) begin bad++; $display("FAIL rd_grant busy=%b addr=%h exp=1/05", busy, ram_addr); end
    total++; if (ram_write !== 1'b0 || ack0 !== 1'b0) begin bad++; $display("FAIL rd_t1 wr=%b ack0=%b exp=0/0", ram_write, ack0); end
    step();
    total++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin bad++; $display("FAIL rd_t2_ack got=%b%b exp=00", ack0, ack1); end
    step();
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL rd_ack0 got=%b exp=1", ack0); end
    total++; if (rdata0 !== 16'hBEEF) begin bad++; $display("FAIL rd_rdata0 got=%h exp=beef", rdata0); end
    total++; if (rdata1 !== 16'h0 || ack1 !== 1'b0 || owner !== 1'b0) begin bad++; $display("FAIL rd_other rdata1=%h ack1=%b owner=%b exp=0/0/0", rdata1, ack1, owner); end
    cmd0 = NONE;
    step();
    total++; if (ack0 !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_done ack0=%b busy=%b exp=0/0", ack0, busy); end
    step();
    total++; if (rdata0 !== 16'hBEEF || busy !== 1'b0) begin bad++; $display("FAIL rd_hold rdata0=%h busy=%b exp=beef/0", rdata0, busy); end
  endtask

  task automatic test_write();
    cmd1 = WR; addr1 = 8'h10; wdata1 = 16'h1234;
    step();
    total++; if (ram_write !== 1'b1 || ram_addr !== 8'h10 || ram_din !== 16'h1234) begin bad++; $display("FAIL wr_cmd we=%b addr=%h din=%h exp=1/10/1234", ram_write, ram_addr, ram_din); end
    total++; if (owner !== 1'b1 || ack1 !== 1'b0) begin bad++; $display("FAIL wr_owner owner=%b ack1=%b exp=1/0", owner, ack1); end
    step();
    total++; if (ram_write !== 1'b0 || ack1 !== 1'b1 || ack0 !== 1'b0) begin bad++; $display("FAIL wr_ack we=%b ack1=%b ack0=%b exp=0/1/0", ram_write, ack1, ack0); end
    cmd1 = NONE;
    step();
    total++; if (busy !== 1'b0 || ack1 !== 1'b0) begin bad++; $display("FAIL wr_done busy=%b ack1=%b exp=0/0", busy, ack1); end
    cmd0 = RD; addr0 = 8'h10;
    step(); step(); step();
    total++; if (ack0 !== 1'b1 || rdata0 !== 16'h1234) begin bad++; $display("FAIL wr_readback ack0=%b rdata0=%h exp=1/1234", ack0, rdata0); end
    total++; if (rdata1 !== 16'h0) begin bad++; $display("FAIL wr_rdata1_hold got=%h exp=0", rdata1); end
    cmd0 = NONE;
    step();
  endtask

  task automatic test_tie();
    int n;
    logic exp_port;
    preload(8'h01, 16'hA001);
    preload(8'h02, 16'hA002);
    do_reset();
    reset = 1'b0;
    cmd0 = RD; addr0 = 8'h01;
    cmd1 = RD; addr1 = 8'h02;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) cmd0 = NONE;
      n = 0;
      do begin step(); n++; end while (!(ack0 || ack1) && n < 20);
`ifdef MEM_ARB_RR_EN
      exp_port = (k == 4) ? 1'b1 : k[0];
`else
      exp_port = (k == 4) ? 1'b1 : 1'b0;
`endif
      total++; if ({ack1, ack0} !== (exp_port ? 2'b10 : 2'b01)) begin bad++; $display("FAIL tie_ack_%0d got=%b%b exp_port=%0d", k, ack1, ack0, exp_port); end
      total++; if (n !== ((k == 0) ? 3 : 4)) begin bad++; $display("FAIL tie_interval_%0d got=%0d exp=%0d", k, n, (k == 0) ? 3 : 4); end
      if (exp_port) begin
        total++; if (rdata1 !== 16'hA002) begin bad++; $display("FAIL tie_rdata1_%0d got=%h exp=a002", k, rdata1); end
      end else begin
        total++; if (rdata0 !== 16'hA001) begin bad++; $display("FAIL tie_rdata0_%0d got=%h exp=a001", k, rdata0); end
      end
    end
    cmd1 = NONE;
    step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tie_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_err();
    step(); step(); step();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_none got=%b exp=0", err); end
    cmd0 = 3'b011;
    step();
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_set err=%b busy=%b exp=1/0", err, busy); end
    cmd0 = NONE;
    step(); step(); step();
    total++; if (err !== 1'b1 || busy !== 1'b0 || ack0 !== 1'b0) begin bad++; $display("FAIL err_sticky err=%b busy=%b ack0=%b exp=1/0/0", err, busy, ack0); end
    do_reset();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    cmd0 = WR; addr0 = 8'h20; wdata0 = 16'h5555;
    step();
    total++; if (ram_write !== 1'b1) begin bad++; $display("FAIL mid_wr_start got=%b exp=1", ram_write); end
    reset = 1'b1; cmd0 = NONE;
    step();
    total++; if (ram_write !== 1'b0 || ack0 !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_abort we=%b ack0=%b busy=%b exp=0/0/0", ram_write, ack0, busy); end
    reset = 1'b0;
    step();
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL mid_no_ack got=%b exp=0", ack0); end
    cmd0 = RD; addr0 = 8'h05;
    n = 0;
    do begin step(); n++; end while (!ack0 && n < 20);
    total++; if (n !== 3 || rdata0 !== 16'hBEEF) begin bad++; $display("FAIL mid_read n=%0d rdata0=%h exp=3/beef", n, rdata0); end
    cmd0 = NONE;
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single synchronous-read RAM between the CPU controller (port 0, instruction fetch and LDR/STR) and a loader/debug requester (port 1). It accepts the codebase's one-hot memory commands, serializes them onto one RAM port, returns read data and a one-cycle acknowledge to the winning requester, and flags malformed commands. It sits between the control FSM/datapath address mux and the RAM instance.

## Interface
- AW, 8: address width.
- DW, 16: data width.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd0  in  3  port 0 command, one-hot: 001 NONE, 010 READ, 100 WRITE.
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- ack0  out  1  port 0 transaction complete, one-cycle pulse.
- rdata0  out  DW  port 0 read data; valid from ack0 cycle, held until next port 0 read completes.
- cmd1, addr1, wdata1, ack1, rdata1: same for port 1.
- ram_addr  out  AW  RAM address, registered.
- ram_din  out  DW  RAM write data, registered.
- ram_write  out  1  RAM write enable, registered.
- ram_dout  in  DW  RAM read data, valid one cycle after ram_addr.
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  port of the current/last granted transaction.
- err  out  1  sticky: a non-legal command code was seen in IDLE.

## Operation
- States: IDLE, RD, RCAP, WR, ACK.
- IDLE: sample both cmd inputs. Legal request = 010 or 100. Select winner, latch its addr/wdata/cmd into ram_addr/ram_din, set owner. READ -> RD; WRITE -> WR (ram_write=1 registered on that edge). No request -> stay IDLE.
- RD: ram_addr held; RAM performs read. -> RCAP.
- RCAP: ram_dout valid; captured into rdata of owner at end of cycle. -> ACK.
- WR: ram_write=1 for exactly this cycle. -> ACK (ram_write cleared on this edge).
- ACK: ack of owner = 1, other ack = 0. -> IDLE.
- Requests are level-held: requester keeps cmd/addr/wdata stable until it sees its ack; arbiter ignores inputs outside IDLE. A cmd still legal in the IDLE cycle after ACK is a new transaction.
- Non-granted requester keeps waiting; it is served on a later IDLE.
- Illegal codes (000, 011, 101, 110, 111) are treated as no request and set err; NONE (001) does not set err.
- Arbitration tie (both legal in same IDLE cycle): per Configuration.
- rdata of the non-owner port never changes.

## Timing
- Reset (sampled at edge): state=IDLE, ram_write=0, ram_addr=0, ram_din=0, ack0=ack1=0, rdata0=rdata1=0, owner=0, err=0, busy=0; round-robin pointer favours port 0.
- Reset mid-transaction aborts it: no ack issued, ram_write low after the reset edge, rdata unchanged-to-0 per reset.
- Read: request in IDLE cycle t -> RD t+1 -> RCAP t+2 -> ack and rdata valid t+3. Next transaction sampled t+4.
- Write: request at t -> ram_write high t+1 -> ack t+2. Next sampled t+3.
- ack is a registered state decode; exactly one pulse per granted transaction.
- Back-to-back throughput: read every 4 cycles, write every 3 cycles.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on tie, grant goes to the port not granted last; pointer updates on each grant.
- MEM_ARB_RR_EN undefined: fixed priority; port 0 (CPU) always wins ties; port 1 served only when port 0 idle in IDLE.
- Single-port requests behave identically in both builds.

## Test plan
- Reset then port 0 READ addr 0x05 with RAM[5]=0xBEEF -> ack0 at t+3, rdata0=0xBEEF, rdata1=0, ack1 never high.
- Port 1 WRITE addr 0x10 data 0x1234 -> ram_write high one cycle at t+1 with ram_addr=0x10, ram_din=0x1234, ack1 at t+2; subsequent port 0 READ 0x10 returns 0x1234.
- Both ports READ continuously (0x01/0x02): RR build acks alternate 0,1,0,1; fixed build only ack0 while cmd0 held, port 1 served once cmd0 drops to 001.
- cmd0=011 for one cycle in IDLE -> no grant, busy stays 0, err=1 and remains 1 until reset; cmd=001 alone never sets err.
- Reset asserted in WR cycle of a port 0 write -> no ack0, ram_write 0 after edge, state IDLE; new read then completes normally with 4-cycle timing.
